uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: arms the receiver, detects frame completion on rx_rdy
// rising edges, buffers received bytes in a small FIFO and flags timeouts/overruns.
module uart_rx_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_en,
  input  logic                       rx_rdy,
  input  logic [7:0]                 rx_data,
  output logic                       rx_en,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, BUSY, FLUSH} state_t;

  state_t          state;
  logic            rdy_q;
  logic [TW-1:0]   timer;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic rise, fall, capture, pop, full, push;

  assign rise    = rx_rdy & ~rdy_q;
  assign fall    = ~rx_rdy & rdy_q;
  assign capture = rise & ((state == ARM) | (state == BUSY));

  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign full      = (fifo_count == CW'(DEPTH));
  assign push      = capture & (~full | pop);

  // Reset high so a receiver holding rx_rdy across reset does not look like a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b1;
    else     rdy_q <= rx_rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rx_en     <= 1'b0;
      timer     <= '0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: the later non-blocking assignment in the same block wins, so a
      // timeout below overrides this clear when both happen in one cycle.
      if (clr_err) frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (host_en) begin
            state <= ARM;
            rx_en <= 1'b1;
          end
        end
        ARM: begin
          if (!host_en) begin
            state <= IDLE;
            rx_en <= 1'b0;
          end else if (fall) begin
            state <= BUSY;
            timer <= '0;
          end
        end
        BUSY: begin
          if (!host_en) begin
            state <= IDLE;
            rx_en <= 1'b0;
          end else if (rise) begin
            state <= ARM;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state     <= FLUSH;
            rx_en     <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FLUSH: begin
          state <= host_en ? ARM : IDLE;
          rx_en <= host_en;
        end
        default: begin
          state <= IDLE;
          rx_en <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the data array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (clr_err) overrun <= 1'b0;
      if (capture & full & ~pop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl: a vector table for the basic receive path,
// then hand-written sequences for overrun, full push/pop, timeout, disable and reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_en;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       frame_err;
  logic       clr_err;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_en    (host_en),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       host_en;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       out_ready;
    logic       clr_err;
    logic       exp_rx_en;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       chk_data;
    logic [2:0] exp_count;
    logic       exp_ovr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic he, logic rr, logic [7:0] rd, logic ordy, logic clr,
                              logic e_en, logic e_v, logic [7:0] e_d, logic c_d,
                              logic [2:0] e_c, logic e_o, logic e_f);
    vec_t v;
    v.host_en = he;  v.rx_rdy = rr;   v.rx_data = rd;   v.out_ready = ordy; v.clr_err = clr;
    v.exp_rx_en = e_en; v.exp_valid = e_v; v.exp_data = e_d; v.chk_data = c_d;
    v.exp_count = e_c;  v.exp_ovr = e_o;   v.exp_ferr = e_f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame from ARM with rx_rdy high: fall, low for low_cycles, then rise carrying d.
  task automatic frame(input logic [7:0] d, input int low_cycles, input logic pop, input logic clr);
    rx_rdy = 1'b0;
    repeat (low_cycles) tick();
    rx_rdy    = 1'b1;
    rx_data   = d;
    out_ready = pop;
    clr_err   = clr;
    tick();
    out_ready = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, "_data"}, {24'h0, out_data}, {24'h0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; host_en = 1'b0; rx_rdy = 1'b1; rx_data = 8'h00;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) tick();
    check("reset_rx_en", {31'h0, rx_en}, 32'h0);
    check("reset_count", {29'h0, fifo_count}, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    check("reset_flags", {30'h0, overrun, frame_err}, 32'h0);
    rst = 1'b0;

    // Basic receive: rise 10 cycles after fall, then pop.
    vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 3'd0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0, 0));
    for (int k = 0; k < 9; k++)
      vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 3'd0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 1, 1, 8'hA5, 1, 3'd1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 1, 0, 1, 0, 8'h00, 0, 3'd0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      host_en = vecs[i].host_en; rx_rdy = vecs[i].rx_rdy; rx_data = vecs[i].rx_data;
      out_ready = vecs[i].out_ready; clr_err = vecs[i].clr_err;
      tick();
      check($sformatf("vec%0d_rx_en", i), {31'h0, rx_en}, {31'h0, vecs[i].exp_rx_en});
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].exp_count});
      check($sformatf("vec%0d_flags", i), {30'h0, overrun, frame_err},
            {30'h0, vecs[i].exp_ovr, vecs[i].exp_ferr});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), {24'h0, out_data}, {24'h0, vecs[i].exp_data});
    end
    out_ready = 1'b0;

    // Overrun: five frames into a four-entry FIFO; clr_err on the dropping rise loses to the set.
    for (int k = 1; k <= 4; k++) frame(8'(k), 3, 1'b0, 1'b0);
    check("ovr_count4", {29'h0, fifo_count}, 32'd4);
    check("ovr_flag_before", {31'h0, overrun}, 32'h0);
    frame(8'h05, 3, 1'b0, 1'b1);
    check("ovr_count_after", {29'h0, fifo_count}, 32'd4);
    check("ovr_flag_set", {31'h0, overrun}, 32'h1);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("ovr_pop%0d", k), 8'(k));
    check("ovr_empty", {30'h0, out_valid, fifo_count != 3'd0}, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_empty_count", {29'h0, fifo_count}, 32'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("ovr_cleared", {31'h0, overrun}, 32'h0);

    // Full FIFO with push and pop in the same cycle.
    for (int k = 0; k < 4; k++) frame(8'h11 + 8'(k), 3, 1'b0, 1'b0);
    frame(8'h15, 3, 1'b1, 1'b0);
    check("full_pp_count", {29'h0, fifo_count}, 32'd4);
    check("full_pp_ovr", {31'h0, overrun}, 32'h0);
    for (int k = 0; k < 4; k++) pop_check($sformatf("full_pp_pop%0d", k), 8'h12 + 8'(k));
    check("full_pp_empty", {31'h0, out_valid}, 32'h0);

    // Timeout: rx_rdy held low for 20 cycles after a fall.
    rx_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("to_rx_en_%0d", i), {31'h0, rx_en}, {31'h0, i != 16});
      check($sformatf("to_ferr_%0d", i), {31'h0, frame_err}, {31'h0, i >= 16});
    end
    check("to_no_push", {29'h0, fifo_count}, 32'h0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("to_ferr_clr", {31'h0, frame_err}, 32'h0);
    rx_rdy = 1'b1; rx_data = 8'h5A;
    tick();
    check("arm_rise_count", {29'h0, fifo_count}, 32'd1);
    pop_check("arm_rise_pop", 8'h5A);

    // Disable mid-frame: host_en drops in BUSY, rise arrives three cycles later.
    rx_rdy = 1'b0;
    repeat (3) tick();
    host_en = 1'b0;
    tick();
    check("dis_rx_en", {31'h0, rx_en}, 32'h0);
    repeat (2) tick();
    rx_rdy = 1'b1; rx_data = 8'h77;
    tick();
    check("dis_no_capture", {29'h0, fifo_count}, 32'h0);
    check("dis_idle_rx_en", {31'h0, rx_en}, 32'h0);

    // Async reset with three stored bytes, frame_err set and rx_rdy high.
    host_en = 1'b1;
    tick();
    frame(8'h31, 3, 1'b0, 1'b0);
    frame(8'h32, 3, 1'b0, 1'b0);
    rx_rdy = 1'b0;
    repeat (18) tick();
    rx_rdy = 1'b1; rx_data = 8'h33;
    tick();
    check("pre_rst_count", {29'h0, fifo_count}, 32'd3);
    check("pre_rst_ferr", {31'h0, frame_err}, 32'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_count", {29'h0, fifo_count}, 32'h0);
    check("arst_rx_en", {31'h0, rx_en}, 32'h0);
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_flags", {30'h0, overrun, frame_err}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("post_rst_no_push", {29'h0, fifo_count}, 32'h0);
    check("post_rst_rx_en", {31'h0, rx_en}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
